axis_video_pattern_gen: RTL

Synthesizable, parametrised AXI4-Stream video source with backpressure: programmable frame size, channel count/width, line and frame blanking, four pattern modes. Replaces the fixed behavioural frame source ahead of gray_world and other pixel pipelines, in simulation and on hardware. Frame framing: tuser = start of frame, tlast = end of line.

---
 rtl/axis_video_pattern_gen.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/axis_video_pattern_gen.sv
// axis_video_pattern_gen
//   AXI4-Stream video frame source with backpressure support. Produces frames of
//   NROWS x NCOL pixels, each pixel NCH channels of CH_W bits (channel 0 in the
//   MSBs). Lines are followed by HBLANK idle cycles and frames by VBLANK idle
//   cycles. tuser marks the first pixel of a frame and tlast the last pixel of
//   a line.
//
// Ports
//   clk_i            system clock
//   rst_i            synchronous active-high reset
//   enable_i         run request, only looked at on frame boundaries
//   mode_i           0 solid, 1 ramp, 2 colour bars, 3 LFSR noise (latched at frame start)
//   solid_color_i    mode-0 pixel value (latched at frame start)
//   m_axis_tready_i  downstream ready
//   m_axis_tvalid_o  pixel valid
//   m_axis_tuser_o   first pixel of frame
//   m_axis_tlast_o   last pixel of line
//   m_axis_tdata_o   pixel data
//   frame_done_o     one-cycle pulse after the last beat of a frame
//   frame_cnt_o      completed frame count, wraps
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | stopped, waiting for enable_i
// S_ACTIVE | presenting pixels, tvalid high
// S_HBLANK | idle cycles between lines
// S_VBLANK | idle cycles after a frame, then start a new frame or stop

module axis_video_pattern_gen #(
  parameter int NROWS  = 550,
  parameter int NCOL   = 367,
  parameter int CH_W   = 8,
  parameter int NCH    = 3,
  parameter int HBLANK = 16,
  parameter int VBLANK = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [1:0]           mode_i,
  input  logic [NCH*CH_W-1:0]  solid_color_i,
  input  logic                 m_axis_tready_i,
  output logic                 m_axis_tvalid_o,
  output logic                 m_axis_tuser_o,
  output logic                 m_axis_tlast_o,
  output logic [NCH*CH_W-1:0]  m_axis_tdata_o,
  output logic                 frame_done_o,
  output logic [15:0]          frame_cnt_o
);

  localparam int DATA_W = NCH * CH_W;
  localparam int COL_W  = $clog2(NCOL);
  localparam int ROW_W  = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int BW     = (NCOL / 8 > 0) ? NCOL / 8 : 1;
  localparam int BCNT_W = (BW > 1) ? $clog2(BW) : 1;
  localparam int MAXB   = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BLK_W  = $clog2(MAXB + 2);

  localparam logic [31:0] LFSR_SEED = 32'hACE10001;
  // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [2:0]          bar_q, bar_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [BLK_W-1:0]    blank_q, blank_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   solid_q, solid_d;
  logic                frame_done_q, frame_done_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                tvalid_q, tvalid_d;
  logic                tuser_q, tuser_d;
  logic                tlast_q, tlast_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic [DATA_W-1:0]   pix;
  logic                beat;
  logic                start_frame;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    bar_d        = bar_q;
    bcnt_d       = bcnt_q;
    blank_d      = blank_q;
    lfsr_d       = lfsr_q;
    mode_d       = mode_q;
    solid_d      = solid_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    start_frame  = 1'b0;
    beat         = tvalid_q & m_axis_tready_i;

    case (state_q)
      S_IDLE: begin
        if (enable_i) start_frame = 1'b1;
      end
      S_ACTIVE: begin
        if (beat) begin
          lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
          if (col_q == COL_W'(NCOL - 1)) begin
            col_d  = '0;
            bar_d  = '0;
            bcnt_d = '0;
            if (row_q == ROW_W'(NROWS - 1)) begin
              row_d        = '0;
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 16'd1;
              if (VBLANK > 0) begin
                state_d = S_VBLANK;
                blank_d = BLK_W'(VBLANK - 1);
              end else if (enable_i) begin
                start_frame = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              row_d = row_q + ROW_W'(1);
              if (HBLANK > 0) begin
                state_d = S_HBLANK;
                blank_d = BLK_W'(HBLANK - 1);
              end
            end
          end else begin
            col_d = col_q + COL_W'(1);
            // bar index steps every BW pixels and sticks at the last bar
            if (bcnt_q == BCNT_W'(BW - 1)) begin
              bcnt_d = '0;
              if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
            end else begin
              bcnt_d = bcnt_q + BCNT_W'(1);
            end
          end
        end
      end
      S_HBLANK: begin
        if (blank_q == '0) state_d = S_ACTIVE;
        else               blank_d = blank_q - BLK_W'(1);
      end
      S_VBLANK: begin
        if (blank_q == '0) begin
          if (enable_i) start_frame = 1'b1;
          else          state_d     = S_IDLE;
        end else begin
          blank_d = blank_q - BLK_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_frame) begin
      state_d = S_ACTIVE;
      mode_d  = mode_i;
      solid_d = solid_color_i;
    end
  end

  // Pixel for the position the counters will hold next cycle, so the output
  // registers always present the pixel that matches the counters.
  always_comb begin
    pix = '0;
    case (mode_d)
      2'd0: pix = solid_d;
      2'd1: begin
        for (int k = 0; k < NCH; k++) pix[k*CH_W +: CH_W] = CH_W'(col_d);
      end
      2'd2: begin
        // bar bit n lights the n-th channel counted from the LSB end,
        // giving the blue / green / red ordering 0000FF, 00FF00, FF0000
        for (int k = 0; k < NCH; k++) pix[k*CH_W +: CH_W] = {CH_W{bar_d[k % 3]}};
      end
      default: begin
        for (int b = 0; b < DATA_W; b++) pix[b] = lfsr_d[b % 32];
      end
    endcase
  end

  always_comb begin
    tvalid_d = (state_d == S_ACTIVE);
    tuser_d  = tvalid_d && (row_d == '0) && (col_d == '0);
    tlast_d  = tvalid_d && (col_d == COL_W'(NCOL - 1));
    tdata_d  = tvalid_d ? pix : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      bar_q        <= '0;
      bcnt_q       <= '0;
      blank_q      <= '0;
      lfsr_q       <= LFSR_SEED;
      mode_q       <= '0;
      solid_q      <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      tvalid_q     <= 1'b0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      bar_q        <= bar_d;
      bcnt_q       <= bcnt_d;
      blank_q      <= blank_d;
      lfsr_q       <= lfsr_d;
      mode_q       <= mode_d;
      solid_q      <= solid_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      tvalid_q     <= tvalid_d;
      tuser_q      <= tuser_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
    end
  end

  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tuser_o  = tuser_q;
  assign m_axis_tlast_o  = tlast_q;
  assign m_axis_tdata_o  = tdata_q;
  assign frame_done_o    = frame_done_q;
  assign frame_cnt_o     = frame_cnt_q;

endmodule
